paddle_input_conditioner: RTL and testbench

// - Front end for the ping_pong game core. Conditions raw board inputs (paddle A, paddle B, start)
//   and feeds them as the core's a, b and start inputs.
// - Per input: 2-FF synchronizer, then a counter debouncer.
// - Per paddle: converts a debounced press into a "swing" window measured in game ticks.
//   The core samples a/b only on its div_clock edges, so a short press is never lost.
//   A held button cannot score a hit on every tick.

---
 rtl/paddle_input_conditioner_if.sv | 22 ++
 rtl/paddle_input_conditioner.sv | 150 +++++++++++++++
 tb/tb_paddle_input_conditioner.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/paddle_input_conditioner_if.sv
// Board-side and core-side signals of the paddle input conditioner.
interface paddle_input_conditioner_if;
  logic tick_in;
  logic btn_a_raw;
  logic btn_b_raw;
  logic start_raw;
  logic a_swing;
  logic b_swing;
  logic start_lvl;
  logic a_press;
  logic b_press;

  modport master (
    output tick_in, btn_a_raw, btn_b_raw, start_raw,
    input  a_swing, b_swing, start_lvl, a_press, b_press
  );

  modport slave (
    input  tick_in, btn_a_raw, btn_b_raw, start_raw,
    output a_swing, b_swing, start_lvl, a_press, b_press
  );
endinterface

// File: rtl/paddle_input_conditioner.sv
// Synchronizes and debounces paddle/start inputs and stretches paddle presses into tick-based swings.
// Optional HOLD_REJECT_EN: a held paddle must be released before it can swing again.
//
// state   | meaning
// S_IDLE  | swing low, waiting for a press event
// S_ARMED | swing high, counting SWING_TICKS tick edges
// S_COOL  | swing low, counting COOL_TICKS tick edges before re-arm/idle
module paddle_input_conditioner #(
  parameter int DB_W        = 20,
  parameter int DB_LIMIT    = 1000000,
  parameter int SWING_TICKS = 2,
  parameter int COOL_TICKS  = 2
) (
  input logic                        clk,
  input logic                        rst_n,
  paddle_input_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_COOL  = 2'd2
  } pad_state_e;

  localparam logic [DB_W-1:0] CNT_LAST      = DB_W'(DB_LIMIT - 1);
  localparam logic [DB_W-1:0] CNT_ONE       = DB_W'(1);
  localparam logic [3:0]      TC_SWING_LAST = 4'(SWING_TICKS - 1);
  localparam logic [3:0]      TC_COOL       = 4'(COOL_TICKS);

  // bit 0 = paddle A, bit 1 = paddle B, bit 2 = start
  logic [2:0]      raw;
  logic [2:0]      s1_q;
  logic [2:0]      s2_q;
  logic [2:0]      stable_q;
  logic [2:0]      stable_prev_q;
  logic [DB_W-1:0] cnt_q [3];
  logic            tk1_q;
  logic            tk2_q;
  logic            tk3_q;
  logic            tick_rise;
  logic [1:0]      press;
  pad_state_e      state_q [2];
  pad_state_e      state_d [2];
  logic [3:0]      tc_q [2];
  logic [3:0]      tc_d [2];
  logic [1:0]      swing_q;

  assign raw       = {bus.start_raw, bus.btn_b_raw, bus.btn_a_raw};
  assign tick_rise = tk2_q & ~tk3_q;
  assign press     = stable_q[1:0] & ~stable_prev_q[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      tk1_q         <= 1'b0;
      tk2_q         <= 1'b0;
      tk3_q         <= 1'b0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      s1_q          <= raw;
      s2_q          <= s1_q;
      stable_prev_q <= stable_q;
      tk1_q         <= bus.tick_in;
      tk2_q         <= tk1_q;
      tk3_q         <= tk2_q;
      // cnt counts consecutive cycles the synced level disagrees with the accepted level
      for (int i = 0; i < 3; i++) begin
        if (s2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_q[i] <= s2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      tc_d[i]    = tc_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (press[i]) begin
            state_d[i] = S_ARMED;
            tc_d[i]    = 4'd0;
          end
        end
        S_ARMED: begin
          if (tick_rise) begin
            if (tc_q[i] == TC_SWING_LAST) begin
              state_d[i] = S_COOL;
              tc_d[i]    = 4'd0;
            end else begin
              tc_d[i] = tc_q[i] + 4'd1;
            end
          end
        end
        S_COOL: begin
          if (tc_q[i] == TC_COOL) begin
`ifdef HOLD_REJECT_EN
            if (!stable_q[i]) state_d[i] = S_IDLE;
`else
            if (stable_q[i]) begin
              state_d[i] = S_ARMED;
              tc_d[i]    = 4'd0;
            end else begin
              state_d[i] = S_IDLE;
            end
`endif
          end else if (tick_rise) begin
            tc_d[i] = tc_q[i] + 4'd1;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          tc_d[i]    = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swing_q <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= S_IDLE;
        tc_q[i]    <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        tc_q[i]    <= tc_d[i];
        swing_q[i] <= (state_d[i] == S_ARMED);
      end
    end
  end

  assign bus.a_swing   = swing_q[0];
  assign bus.b_swing   = swing_q[1];
  assign bus.start_lvl = stable_q[2];
  assign bus.a_press   = press[0];
  assign bus.b_press   = press[1];

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Bench for paddle_input_conditioner: directed scenarios plus random stimulus against a reference model.
module tb_paddle_input_conditioner;
  localparam int DB_LIMIT = 4;
  localparam int SWING    = 2;
  localparam int COOL     = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  paddle_input_conditioner_if bus ();

  paddle_input_conditioner #(
    .DB_W(20), .DB_LIMIT(DB_LIMIT), .SWING_TICKS(SWING), .COOL_TICKS(COOL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  // game tick: period 40 clk, changes on falling clk edges
  initial begin
    bus.tick_in = 1'b0;
    forever begin
      repeat (20) @(negedge clk);
      bus.tick_in = ~bus.tick_in;
    end
  end

  // Reference model: raw history -> run-length debounce -> tick-countdown swing/cool phases.
  bit [2:0] m_p0, m_p1, m_p2;
  bit       m_t0, m_t1, m_t2;
  bit [2:0] m_st;
  int       m_run [3];
  bit [1:0] m_press;
  int       m_mode [2];   // 0 idle, 1 swinging, 2 cooling
  int       m_rem [2];    // tick edges left in the current phase
  bit       m_tr;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_p0 = '0; m_p1 = '0; m_p2 = '0;
        m_t0 = 0; m_t1 = 0; m_t2 = 0;
        m_st = '0; m_press = '0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        for (int p = 0; p < 2; p++) begin m_mode[p] = 0; m_rem[p] = 0; end
      end else begin
        m_tr = m_t1 & ~m_t2;
        for (int p = 0; p < 2; p++) begin
          if (m_mode[p] == 0) begin
            if (m_press[p]) begin m_mode[p] = 1; m_rem[p] = SWING; end
          end else if (m_mode[p] == 1) begin
            if (m_tr) begin
              m_rem[p]--;
              if (m_rem[p] == 0) begin m_mode[p] = 2; m_rem[p] = COOL; end
            end
          end else begin
            if (m_rem[p] == 0) begin
`ifdef HOLD_REJECT_EN
              if (!m_st[p]) m_mode[p] = 0;
`else
              if (m_st[p]) begin m_mode[p] = 1; m_rem[p] = SWING; end
              else m_mode[p] = 0;
`endif
            end else if (m_tr) begin
              m_rem[p]--;
            end
          end
        end
        for (int i = 0; i < 3; i++) begin
          if (m_p1[i] != m_st[i]) begin
            m_run[i]++;
            if (m_run[i] == DB_LIMIT) begin
              m_st[i] = m_p1[i];
              m_run[i] = 0;
              if (i < 2 && m_st[i]) m_press[i] = 1'b1;
            end else if (i < 2) m_press[i] = 1'b0;
          end else begin
            m_run[i] = 0;
            if (i < 2) m_press[i] = 1'b0;
          end
        end
        m_p2 = m_p1; m_p1 = m_p0;
        m_p0 = {bus.start_raw, bus.btn_b_raw, bus.btn_a_raw};
        m_t2 = m_t1; m_t1 = m_t0; m_t0 = bus.tick_in;
      end
    end
  end

  task automatic test_reset();
    logic [4:0] obs;
    rst_n = 1'b0;
    bus.btn_a_raw = 0; bus.btn_b_raw = 0; bus.start_raw = 0;
    repeat (3) @(negedge clk);
    obs = {bus.a_swing, bus.b_swing, bus.start_lvl, bus.a_press, bus.b_press};
    checks++;
    if (obs !== 5'b0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", obs, 5'b0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    obs = {bus.a_swing, bus.b_swing, bus.start_lvl, bus.a_press, bus.b_press};
    checks++;
    if (obs !== 5'b0) begin
      failures++; $display("FAIL idle_after_reset got=%b exp=%b", obs, 5'b0);
    end
  endtask

  task automatic test_glitch_latency();
    int np = 0, ns = 0;
    @(negedge clk);
    bus.btn_a_raw = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) bus.btn_a_raw = 0;
      np += int'(bus.a_press);
      ns += int'(bus.a_swing);
    end
    checks++;
    if (np != 0 || ns != 0) begin
      failures++; $display("FAIL glitch_ignored got press=%0d swing=%0d exp=0", np, ns);
    end
    @(negedge clk);
    bus.btn_a_raw = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 10) bus.btn_a_raw = 0;
      checks++;
      if (bus.a_press !== (k == 6)) begin
        failures++; $display("FAIL press_latency k=%0d got=%b exp=%b", k, bus.a_press, k == 6);
      end
      checks++;
      if (bus.a_swing !== (k >= 7)) begin
        failures++; $display("FAIL swing_latency k=%0d got=%b exp=%b", k, bus.a_swing, k >= 7);
      end
    end
    bus.btn_a_raw = 0;
    repeat (200) @(negedge clk);
  endtask

  task automatic test_short_press();
    int cnt = 0, first = -1;
    @(negedge bus.tick_in);
    bus.btn_a_raw = 1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (k == 4) bus.btn_a_raw = 0;
      if (bus.a_swing === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (first != 7) begin
      failures++; $display("FAIL short_swing_start got=%0d exp=7", first);
    end
    checks++;
    if (cnt != 56) begin
      failures++; $display("FAIL short_swing_width got=%0d exp=56", cnt);
    end
    repeat (100) @(negedge clk);
  endtask

  task automatic test_hold();
    int rises = 0;
    logic prev = 0;
    @(negedge clk);
    bus.btn_a_raw = 1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.a_swing === 1'b1 && prev === 1'b0) rises++;
      prev = bus.a_swing;
    end
`ifdef HOLD_REJECT_EN
    checks++;
    if (rises != 1) begin
      failures++; $display("FAIL hold_single_swing got=%0d exp=1", rises);
    end
    checks++;
    if (bus.a_swing !== 1'b0) begin
      failures++; $display("FAIL hold_swing_low got=%b exp=0", bus.a_swing);
    end
`else
    checks++;
    if (rises < 2) begin
      failures++; $display("FAIL hold_autorepeat got=%0d exp>=2", rises);
    end
`endif
    bus.btn_a_raw = 0;
    repeat (200) @(negedge clk);
  endtask

  task automatic test_both();
    int npa = 0, seen = 0;
    @(negedge clk);
    bus.btn_a_raw = 1; bus.btn_b_raw = 1;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (k == 10) begin bus.btn_a_raw = 0; bus.btn_b_raw = 0; end
      npa  += int'(bus.a_press);
      seen += int'(bus.a_swing);
      checks++;
      if (bus.a_press !== bus.b_press || bus.a_swing !== bus.b_swing) begin
        failures++;
        $display("FAIL both_equal k=%0d got a=%b%b b=%b%b", k, bus.a_press, bus.a_swing,
                 bus.b_press, bus.b_swing);
      end
    end
    checks++;
    if (npa != 1 || seen == 0) begin
      failures++; $display("FAIL both_pulse got press=%0d swing_cycles=%0d exp press=1 swing>0", npa, seen);
    end
    repeat (100) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int found = 0, bad = 0;
    @(negedge clk);
    bus.btn_a_raw = 1;
    for (int k = 0; k < 30 && found == 0; k++) begin
      @(negedge clk);
      if (bus.a_swing === 1'b1) found = 1;
    end
    checks++;
    if (found == 0) begin
      failures++; $display("FAIL reset_mid_arm got swing=0 exp=1 within 30 clk");
    end
    bus.btn_a_raw = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.a_swing !== 1'b0) begin
      failures++; $display("FAIL reset_async got=%b exp=0", bus.a_swing);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ({bus.a_swing, bus.b_swing, bus.start_lvl, bus.a_press, bus.b_press} !== 5'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL reset_quiet got=%0d nonzero cycles exp=0", bad);
    end
  endtask

  task automatic test_start_bounce();
    logic [7:0] pat = 8'b11001100;
    int bad = 0, rises = 0, first = -1;
    logic prev = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.start_raw = pat[7-i];
      if (bus.start_lvl !== 1'b0) bad++;
    end
    @(negedge clk);
    bus.start_raw = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.start_lvl === 1'b1 && prev === 1'b0) begin
        rises++;
        if (first < 0) first = k;
      end
      prev = bus.start_lvl;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL start_bounce_low got=%0d exp=0", bad);
    end
    checks++;
    if (first != 6 || rises != 1) begin
      failures++; $display("FAIL start_rise got k=%0d rises=%0d exp k=6 rises=1", first, rises);
    end
    bus.start_raw = 0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    int hold [3];
    logic [4:0] obs, exp;
    for (int i = 0; i < 3; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      obs = {bus.a_swing, bus.b_swing, bus.start_lvl, bus.a_press, bus.b_press};
      exp = {m_mode[0] == 1, m_mode[1] == 1, m_st[2], m_press[0], m_press[1]};
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL random_model cyc=%0d got=%b exp=%b", c, obs, exp);
      end
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 90) : $urandom_range(1, 7);
          case (i)
            0: bus.btn_a_raw = 1'($urandom_range(0, 1));
            1: bus.btn_b_raw = 1'($urandom_range(0, 1));
            default: bus.start_raw = 1'($urandom_range(0, 1));
          endcase
        end else begin
          hold[i]--;
        end
      end
    end
  endtask

  initial begin
    bus.btn_a_raw = 0; bus.btn_b_raw = 0; bus.start_raw = 0;
    test_reset();
    test_glitch_latency();
    test_short_press();
    test_hold();
    test_both();
    test_reset_mid();
    test_start_bounce();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
